// File: rtl/cm_sketch_decay.sv
// Count-min sketch with query-only lookups and clear/halve decay sweeps.
// Pipeline: S1 hash capture, S2 counter read-modify-write, S3 min reduction.

module cm_sketch_decay #(
  parameter int W         = 1024,
  parameter int IDX_SIZE  = $clog2(W),
  parameter int NUM_HASH  = 4,
  parameter int ADDR_SIZE = 22,
  parameter int CNT_SIZE  = 18
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 input_valid,
  output logic                 input_ready,
  input  logic [ADDR_SIZE-1:0] input_addr,
  input  logic                 input_query,
  input  logic                 flush_req,
  input  logic                 flush_mode,
  output logic                 flush_busy,
  output logic                 flush_done,
  output logic                 output_valid,
  output logic [ADDR_SIZE-1:0] output_addr,
  output logic [CNT_SIZE-1:0]  output_cnt,
  output logic                 output_query
);

  typedef enum logic [1:0] {IDLE, DRAIN, SWEEP} state_t;

  // Row hash: fold the address with a copy of itself rotated right by sh.
  function automatic logic [IDX_SIZE-1:0] hash_row(input logic [ADDR_SIZE-1:0] a,
                                                   input int unsigned sh);
    logic [ADDR_SIZE-1:0] rot;
    rot = (a >> sh) | (a << (ADDR_SIZE - sh));
    return rot[IDX_SIZE-1:0] ^ a[IDX_SIZE-1:0];
  endfunction

  state_t                state;
  logic                  mode;
  logic [IDX_SIZE-1:0]   ptr;
  logic                  accept;

  logic                  s1_valid;
  logic                  s1_query;
  logic [ADDR_SIZE-1:0]  s1_addr;
  logic [IDX_SIZE-1:0]   s1_idx [NUM_HASH];

  logic                  s2_valid;
  logic                  s2_query;
  logic [ADDR_SIZE-1:0]  s2_addr;
  logic [CNT_SIZE-1:0]   s2_cnt [NUM_HASH];

  logic [IDX_SIZE-1:0]   hash_idx [NUM_HASH];
  logic [CNT_SIZE-1:0]   rd_cnt   [NUM_HASH];
  logic [CNT_SIZE-1:0]   nxt_cnt  [NUM_HASH];
  logic [CNT_SIZE-1:0]   min_cnt;

  logic [CNT_SIZE-1:0]   cnt [NUM_HASH][W];

  assign accept = input_valid & input_ready;

  // NOTE: every always_comb output gets a value on every path (here via the
  // loop or a leading default), otherwise synthesis infers a latch.
  always_comb begin
    for (int i = 0; i < NUM_HASH; i++) begin
      hash_idx[i] = hash_row(input_addr, IDX_SIZE + i);
      rd_cnt[i]   = cnt[i][s1_idx[i]];
      nxt_cnt[i]  = (s1_query || (&rd_cnt[i])) ? rd_cnt[i] : rd_cnt[i] + 1'b1;
    end
  end

  // NOTE: blocking assignments in combinational logic, so the running minimum
  // is visible to the next loop iteration; registers below use <= only.
  always_comb begin
    min_cnt = s2_cnt[0];
    for (int i = 1; i < NUM_HASH; i++) begin
      if (s2_cnt[i] < min_cnt) min_cnt = s2_cnt[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_query <= 1'b0;
      s1_addr  <= '0;
      s2_valid <= 1'b0;
      s2_query <= 1'b0;
      s2_addr  <= '0;
      for (int i = 0; i < NUM_HASH; i++) begin
        s1_idx[i] <= '0;
        s2_cnt[i] <= '0;
      end
      output_valid <= 1'b0;
      output_addr  <= '0;
      output_cnt   <= '0;
      output_query <= 1'b0;
    end else begin
      s1_valid <= accept;
      s1_query <= input_query;
      s1_addr  <= input_addr;
      for (int i = 0; i < NUM_HASH; i++) s1_idx[i] <= hash_idx[i];
      s2_valid <= s1_valid;
      s2_query <= s1_query;
      s2_addr  <= s1_addr;
      for (int i = 0; i < NUM_HASH; i++) s2_cnt[i] <= nxt_cnt[i];
      output_valid <= s2_valid;
      output_addr  <= s2_addr;
      output_cnt   <= min_cnt;
      output_query <= s2_query;
    end
  end

  // NOTE: the counter array is built from flops rather than RAM because reset
  // must clear it; a sweep write and an S2 update can never coincide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_HASH; r++)
        for (int c = 0; c < W; c++)
          cnt[r][c] <= '0;
    end else if (state == SWEEP) begin
      for (int r = 0; r < NUM_HASH; r++)
        cnt[r][ptr] <= mode ? (cnt[r][ptr] >> 1) : '0;
    end else if (s1_valid && !s1_query) begin
      for (int r = 0; r < NUM_HASH; r++)
        cnt[r][s1_idx[r]] <= nxt_cnt[r];
    end
  end

  // Flush control; the only pending counter write sits in S1, so DRAIN waits
  // just for S1 to empty before the sweep may start touching columns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      mode        <= 1'b0;
      ptr         <= '0;
      input_ready <= 1'b1;
      flush_busy  <= 1'b0;
      flush_done  <= 1'b0;
    end else begin
      flush_done <= 1'b0;
      case (state)
        IDLE: begin
          if (flush_req) begin
            state       <= DRAIN;
            mode        <= flush_mode;
            flush_busy  <= 1'b1;
            input_ready <= 1'b0;
          end
        end
        DRAIN: begin
          if (!s1_valid) begin
            state <= SWEEP;
            ptr   <= '0;
          end
        end
        SWEEP: begin
          ptr <= ptr + 1'b1;
          if (ptr == IDX_SIZE'(W - 1)) begin
            state       <= IDLE;
            flush_busy  <= 1'b0;
            input_ready <= 1'b1;
            flush_done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cm_sketch_decay.sv
// Self-checking bench: two sketches (18-bit and 4-bit counters) share stimulus
// and are compared every cycle against an array-based count-min model.

module tb_cm_sketch_decay;

  localparam int W   = 64;
  localparam int IDX = 6;
  localparam int NH  = 4;
  localparam int AW  = 22;
  localparam int CW  = 18;
  localparam int CWS = 4;
  localparam int unsigned MAX18 = (1 << CW) - 1;
  localparam int unsigned MAX4  = (1 << CWS) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          input_valid = 1'b0;
  logic [AW-1:0] input_addr  = '0;
  logic          input_query = 1'b0;
  logic          flush_req   = 1'b0;
  logic          flush_mode  = 1'b0;

  logic          ready_a, busy_a, done_a, ovalid_a, oquery_a;
  logic [AW-1:0] oaddr_a;
  logic [CW-1:0] ocnt_a;
  logic          ready_b, busy_b, done_b, ovalid_b, oquery_b;
  logic [AW-1:0] oaddr_b;
  logic [CWS-1:0] ocnt_b;

  cm_sketch_decay #(.W(W), .NUM_HASH(NH), .ADDR_SIZE(AW), .CNT_SIZE(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .input_valid(input_valid), .input_ready(ready_a),
    .input_addr(input_addr), .input_query(input_query),
    .flush_req(flush_req), .flush_mode(flush_mode),
    .flush_busy(busy_a), .flush_done(done_a),
    .output_valid(ovalid_a), .output_addr(oaddr_a),
    .output_cnt(ocnt_a), .output_query(oquery_a)
  );

  cm_sketch_decay #(.W(W), .NUM_HASH(NH), .ADDR_SIZE(AW), .CNT_SIZE(CWS)) dut_sat (
    .clk(clk), .rst_n(rst_n),
    .input_valid(input_valid), .input_ready(ready_b),
    .input_addr(input_addr), .input_query(input_query),
    .flush_req(flush_req), .flush_mode(flush_mode),
    .flush_busy(busy_b), .flush_done(done_b),
    .output_valid(ovalid_b), .output_addr(oaddr_b),
    .output_cnt(ocnt_b), .output_query(oquery_b)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit chk_en = 1'b0;
  bit in_flush = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  int unsigned m18 [NH][W];
  int unsigned m4  [NH][W];

  typedef struct {
    int            due;
    logic [AW-1:0] addr;
    int unsigned   c18;
    int unsigned   c4;
    bit            q;
  } exp_t;
  exp_t expq[$];

  // Column of row r: low bits of addr XOR addr rotated right by IDX+r.
  function automatic int unsigned hidx(input logic [AW-1:0] a, input int r);
    logic [2*AW-1:0] d;
    d = {a, a} >> (IDX + r);
    return 32'(d[IDX-1:0] ^ a[IDX-1:0]);
  endfunction

  task automatic model_accept(input logic [AW-1:0] a, input bit q,
                              output int unsigned e18, output int unsigned e4);
    exp_t e;
    e18 = 32'hFFFF_FFFF;
    e4  = 32'hFFFF_FFFF;
    for (int r = 0; r < NH; r++) begin
      int unsigned k;
      k = hidx(a, r);
      if (!q) begin
        if (m18[r][k] < MAX18) m18[r][k] = m18[r][k] + 1;
        if (m4[r][k]  < MAX4)  m4[r][k]  = m4[r][k] + 1;
      end
      if (m18[r][k] < e18) e18 = m18[r][k];
      if (m4[r][k]  < e4)  e4  = m4[r][k];
    end
    e.due = cyc + 3; e.addr = a; e.c18 = e18; e.c4 = e4; e.q = q;
    expq.push_back(e);
  endtask

  task automatic model_flush(input bit halve);
    for (int r = 0; r < NH; r++)
      for (int k = 0; k < W; k++) begin
        m18[r][k] = halve ? m18[r][k] / 2 : 0;
        m4[r][k]  = halve ? m4[r][k] / 2 : 0;
      end
  endtask

  task automatic model_reset();
    for (int r = 0; r < NH; r++)
      for (int k = 0; k < W; k++) begin
        m18[r][k] = 0;
        m4[r][k]  = 0;
      end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    bit ev;
    if (chk_en) begin
      ev = (expq.size() > 0) && (expq[0].due == cyc);
      check("out_valid", ovalid_a, ev);
      check("out_valid_sat", ovalid_b, ev);
      if (ev) begin
        check("out_addr", oaddr_a, expq[0].addr);
        check("out_cnt", ocnt_a, expq[0].c18);
        check("out_query", oquery_a, expq[0].q);
        check("out_addr_sat", oaddr_b, expq[0].addr);
        check("out_cnt_sat", ocnt_b, expq[0].c4);
        check("out_query_sat", oquery_b, expq[0].q);
        void'(expq.pop_front());
      end
      while (expq.size() > 0 && expq[0].due < cyc) void'(expq.pop_front());
      if (!in_flush) begin
        check("ready_idle", ready_a, 1);
        check("busy_idle", busy_a, 0);
        check("done_idle", done_a, 0);
        check("ready_idle_sat", ready_b, 1);
        check("done_idle_sat", done_b, 0);
      end
    end
  end

  // ---------------- driver tasks (entered at a negedge) ----------------
  task automatic idle(input int n);
    input_valid = 1'b0;
    flush_req   = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic req(input logic [AW-1:0] a, input bit q,
                     output int unsigned e18, output int unsigned e4);
    input_valid = 1'b1;
    input_addr  = a;
    input_query = q;
    model_accept(a, q, e18, e4);
    @(negedge clk);
    input_valid = 1'b0;
  endtask

  task automatic flush(input bit halve, input bit with_req,
                       input logic [AW-1:0] a, input bit q);
    int nbusy;
    int ndone;
    int unsigned e18, e4;
    nbusy = 0;
    ndone = 0;
    in_flush   = 1'b1;
    flush_req  = 1'b1;
    flush_mode = halve;
    if (with_req) begin
      input_valid = 1'b1;
      input_addr  = a;
      input_query = q;
      model_accept(a, q, e18, e4);
    end
    model_flush(halve);
    @(negedge clk);
    flush_req   = 1'b0;
    input_valid = 1'b0;
    for (int i = 0; i < W + 10 && ndone == 0; i++) begin
      if (done_a) begin
        ndone++;
        check("done_busy_low", busy_a, 0);
        check("done_ready_high", ready_a, 1);
        check("done_sat", done_b, 1);
      end else begin
        nbusy++;
        check("flush_busy", busy_a, 1);
        check("flush_ready_low", ready_a, 0);
        check("flush_busy_sat", busy_b, 1);
      end
      @(negedge clk);
    end
    check("flush_done_seen", ndone, 1);
    check("flush_busy_max", nbusy <= W + 2, 1);
    check("flush_busy_min", nbusy >= W, 1);
    check("flush_done_pulse", done_a, 0);
    in_flush = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ready"}, ready_a, 1);
    check({tag, "_busy"}, busy_a, 0);
    check({tag, "_done"}, done_a, 0);
    check({tag, "_valid"}, ovalid_a, 0);
    check({tag, "_addr"}, oaddr_a, 0);
    check({tag, "_cnt"}, ocnt_a, 0);
    check({tag, "_query"}, oquery_a, 0);
    check({tag, "_done_sat"}, done_b, 0);
    check({tag, "_valid_sat"}, ovalid_b, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int unsigned e18, e4;
    logic [AW-1:0] pool [12];
    logic [AW-1:0] a;

    model_reset();
    @(negedge clk);
    check_reset_vals("reset");
    @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    idle(2);

    // Back-to-back updates, then queries, then one more update.
    req(22'h00ABC, 0, e18, e4); check("pin_upd1", e18, 1);
    req(22'h00ABC, 0, e18, e4); check("pin_upd2", e18, 2);
    req(22'h00ABC, 0, e18, e4); check("pin_upd3", e18, 3);
    req(22'h00ABC, 1, e18, e4); check("pin_qry1", e18, 3);
    req(22'h00ABC, 1, e18, e4); check("pin_qry2", e18, 3);
    req(22'h00ABC, 0, e18, e4); check("pin_upd4", e18, 4);
    req(22'h00ABC, 0, e18, e4); check("pin_upd5", e18, 5);
    idle(4);

    // Halve twice, then clear.
    flush(1, 0, '0, 0);
    req(22'h00ABC, 1, e18, e4); check("pin_halve1", e18, 2);
    idle(3);
    flush(1, 0, '0, 0);
    req(22'h00ABC, 1, e18, e4); check("pin_halve2", e18, 1);
    idle(3);
    flush(0, 0, '0, 0);
    req(22'h00ABC, 1, e18, e4); check("pin_clear", e18, 0);
    req(22'h3FFFF, 1, e18, e4); check("pin_clear_other", e18, 0);
    idle(4);

    // Flush requested in the same cycle as update #2 of a stream.
    req(22'h2F0F0, 0, e18, e4); check("pin_inflight1", e18, 1);
    flush(0, 1, 22'h2F0F0, 0);
    req(22'h2F0F0, 1, e18, e4); check("pin_after_flush", e18, 0);
    idle(4);

    // Saturation: 20 updates, 4-bit copy must stick at 15.
    for (int i = 1; i <= 20; i++) begin
      req(22'h12345, 0, e18, e4);
      check("pin_sat18", e18, i);
      check("pin_sat4", e4, (i < 15) ? i : 15);
    end
    idle(4);

    // Randomized traffic over a small address pool.
    for (int i = 0; i < 12; i++) pool[i] = AW'($urandom);
    for (int n = 0; n < 1200; n++) begin
      int unsigned r;
      r = $urandom_range(0, 99);
      a = ($urandom_range(0, 9) == 0) ? AW'($urandom) : pool[$urandom_range(0, 11)];
      if (r < 60)      req(a, 0, e18, e4);
      else if (r < 80) req(a, 1, e18, e4);
      else if (r < 96) idle(1);
      else             flush(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a,
                             1'($urandom_range(0, 1)));
    end
    idle(5);

    // Reset in the middle of a halving sweep.
    for (int i = 0; i < 3; i++) req(22'h00ABC, 0, e18, e4);
    for (int i = 0; i < 2; i++) req(22'h3FFFF, 0, e18, e4);
    idle(4);
    in_flush   = 1'b1;
    flush_req  = 1'b1;
    flush_mode = 1'b1;
    @(negedge clk);
    flush_req = 1'b0;
    for (int i = 0; i < 31; i++) begin
      check("sweep_busy", busy_a, 1);
      @(negedge clk);
    end
    chk_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check_reset_vals("midreset");
    @(negedge clk);
    check_reset_vals("midreset_hold");
    expq.delete();
    model_reset();
    rst_n    = 1'b1;
    in_flush = 1'b0;
    chk_en   = 1'b1;
    for (int i = 0; i < 80; i++) begin
      if (done_a || done_b) check("no_done_after_reset", 1, 0);
      @(negedge clk);
    end
    req(22'h00ABC, 1, e18, e4); check("pin_reset_q1", e18, 0);
    req(22'h3FFFF, 1, e18, e4); check("pin_reset_q2", e18, 0);
    req(pool[0], 1, e18, e4);
    idle(6);
    check("queue_drained", expq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
